// File: rtl/arb_requester_if.sv
// Requester <-> client/arbiter signal bundle for arb_requester.
interface arb_requester_if #(
   parameter int LEN_W = 4
);
   logic             start;
   logic [LEN_W-1:0] len;
   logic             gnt;
   logic             req;
   logic             busy;
   logic             beat;
   logic [LEN_W-1:0] beat_idx;
   logic             done;
   logic             err;

   // The requester block itself
   modport master (
      input  start, len, gnt,
      output req, busy, beat, beat_idx, done, err
   );

   // Client/arbiter side driving the requester
   modport slave (
      output start, len, gnt,
      input  req, busy, beat, beat_idx, done, err
   );
endinterface

// File: rtl/arb_requester.sv
// Arbiter requester: takes a burst job from a local client, requests the
// arbiter, counts granted beats, and releases the grant with done/err pulses.
module arb_requester #(
   parameter int LEN_W       = 4,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic            clock,
   input  logic            reset_n,
   arb_requester_if.master bus
);
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   typedef enum logic [1:0] {IDLE, WAIT, XFER, REL} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic [LEN_W-1:0] len_q, len_d, len_last;
   logic [LEN_W-1:0] idx_q, idx_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   // Saturating wait/release counter; the timeout compare fires first in
   // practice, saturation only guards against ever wrapping.
   assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
   assign len_last = len_q - LEN_W'(1);

   // State, counters and registered done/err pulses
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         len_q   <= '0;
         idx_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // Next-state and next-pulse decode; start is only looked at in IDLE
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      idx_d   = idx_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (bus.len != '0) begin
                  len_d   = bus.len;
                  cnt_d   = '0;
                  state_d = WAIT;
               end else begin
                  // zero-length job finishes without touching the arbiter
                  done_d = 1'b1;
               end
            end
         end
         WAIT: begin
            if (bus.gnt) begin
               idx_d   = '0;
               state_d = XFER;
            end else if (cnt_q == CNT_LAST) begin
               err_d   = 1'b1;
               cnt_d   = '0;
               state_d = REL;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         XFER: begin
            if (!bus.gnt) begin
               // grant lost mid-burst
               err_d   = 1'b1;
               cnt_d   = '0;
               state_d = REL;
            end else if (idx_q == len_last) begin
               // last beat: index stays on it
               cnt_d   = '0;
               state_d = REL;
            end else begin
               idx_d = idx_q + LEN_W'(1);
            end
         end
         REL: begin
            if (!bus.gnt) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end else if (cnt_q == CNT_LAST) begin
               // arbiter never dropped grant: give up and report
               done_d  = 1'b1;
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.req      = (state_q == WAIT) || (state_q == XFER);
   assign bus.busy     = (state_q != IDLE);
   assign bus.beat     = (state_q == XFER) && bus.gnt;
   assign bus.beat_idx = idx_q;
   assign bus.done     = done_q;
   assign bus.err      = err_q;
endmodule

// File: tb/tb_arb_requester.sv
// Self-checking bench for arb_requester: each scenario drives a job and
// compares collected beats/pulses against a job-level timing model.
module tb_arb_requester;
   localparam int LW = 4;
   localparam int T  = 16;

   logic clock = 1'b0;
   logic reset_n;
   int   cyc = 0;

   arb_requester_if #(.LEN_W(LW)) bus ();

   arb_requester #(.LEN_W(LW), .TIMEOUT_CYC(T)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;
   bit mon_en = 1'b0;
   int t0;

   // observations
   int beat_q[$], beat_cyc_q[$], done_q[$], err_q[$];
   int req_cnt, req_first, req_last;

   // expectations
   int e_nb, e_x, e_r, e_done;
   int e_errq[$];

   // collect outputs once per cycle, away from the rising edge
   always @(negedge clock) begin
      if (mon_en) begin
         if (bus.beat === 1'b1) begin
            beat_q.push_back(int'(bus.beat_idx));
            beat_cyc_q.push_back(cyc);
         end
         if (bus.done === 1'b1) done_q.push_back(cyc);
         if (bus.err === 1'b1) err_q.push_back(cyc);
         if (bus.req === 1'b1) begin
            if (req_cnt == 0) req_first = cyc;
            req_last = cyc;
            req_cnt++;
         end
      end
   end

   // Job-level model. Start is issued in cycle t0; gnt is high in cycles
   // [t0+1+d, t0+d+W]. WAIT spans t0+1..t0+T, a grant seen there opens XFER
   // the next cycle, each granted XFER cycle is one beat, and REL waits for
   // gnt low (done one cycle later) or gives up after T granted cycles.
   task automatic model(input int L, input int d, input int W);
      int ws, we, gh;
      ws = t0 + 1 + d;
      we = t0 + d + W;
      e_errq = {};
      e_nb = 0;
      e_x = 0;
      if (L == 0) begin
         e_done = t0 + 1;
         e_r = t0 + 1;
         return;
      end
      if (W > 0 && d <= T - 1) begin
         e_x = ws + 1;
         if (W - 1 >= L) begin
            e_nb = L;
            e_r = e_x + L;
         end else begin
            e_nb = W - 1;
            e_r = e_x + e_nb + 1;
            e_errq.push_back(e_r);
         end
      end else begin
         e_r = t0 + 1 + T;
         e_errq.push_back(e_r);
      end
      gh = (W > 0 && e_r >= ws && e_r <= we) ? we - e_r + 1 : 0;
      if (gh >= T) begin
         e_done = e_r + T;
         e_errq.push_back(e_done);
      end else begin
         e_done = e_r + gh + 1;
      end
   endtask

   task automatic run_job(input int L, input int d, input int W, input bit pulse_busy, input bit started);
      int last;
      beat_q = {}; beat_cyc_q = {}; done_q = {}; err_q = {};
      req_cnt = 0; req_first = -1; req_last = -1;
      if (!started) begin
         @(posedge clock); #1;
         bus.start = 1'b1;
         bus.len = LW'(L);
         t0 = cyc;
      end
      mon_en = 1'b1;
      model(L, d, W);
      last = ((e_done > t0 + d + W) ? e_done : t0 + d + W) + 3;
      while (cyc < last) begin
         @(posedge clock); #1;
         bus.start = 1'b0;
         bus.gnt = (W > 0 && cyc >= t0 + 1 + d && cyc <= t0 + d + W);
         if (pulse_busy && L != 0 && (cyc == t0 + 2 || cyc == e_done - 1)) begin
            bus.start = 1'b1;
            bus.len = LW'($urandom_range(0, 15));
         end
      end
      mon_en = 1'b0;
      bus.gnt = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b1;
      bus.start = 1'b0; bus.len = '0; bus.gnt = 1'b0;
      #1 reset_n = 1'b0;
      #3;
      checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL reset req got=%b exp=0", bus.req); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset busy got=%b exp=0", bus.busy); end
      checks++; if (bus.beat !== 1'b0) begin errors++; $display("FAIL reset beat got=%b exp=0", bus.beat); end
      checks++; if (bus.beat_idx !== 4'd0) begin errors++; $display("FAIL reset beat_idx got=%0d exp=0", bus.beat_idx); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset done got=%b exp=0", bus.done); end
      checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset err got=%b exp=0", bus.err); end
      repeat (2) @(posedge clock);
      #3 reset_n = 1'b1;
   endtask

   task automatic test_basic();
      run_job(3, 2, 4, 1'b0, 1'b0);
      checks++; if (beat_q.size() != 3) begin errors++; $display("FAIL basic nbeats got=%0d exp=3", beat_q.size()); end
      for (int i = 0; i < beat_q.size(); i++) begin
         checks++; if (beat_q[i] != i) begin errors++; $display("FAIL basic beat_idx[%0d] got=%0d exp=%0d", i, beat_q[i], i); end
         checks++; if (beat_cyc_q[i] != e_x + i) begin errors++; $display("FAIL basic beat_cyc[%0d] got=%0d exp=%0d", i, beat_cyc_q[i], e_x + i); end
      end
      checks++; if (req_first != t0 + 1) begin errors++; $display("FAIL basic req_rise got=%0d exp=%0d", req_first, t0 + 1); end
      checks++; if (req_last != e_x + 2) begin errors++; $display("FAIL basic req_fall got=%0d exp=%0d", req_last, e_x + 2); end
      checks++; if (done_q.size() != 1) begin errors++; $display("FAIL basic ndone got=%0d exp=1", done_q.size()); end
      checks++; if ((done_q.size() > 0 ? done_q[0] : -1) != e_done) begin errors++; $display("FAIL basic done_cyc got=%0d exp=%0d", (done_q.size() > 0 ? done_q[0] : -1), e_done); end
      checks++; if (err_q.size() != 0) begin errors++; $display("FAIL basic nerr got=%0d exp=0", err_q.size()); end
   endtask

   task automatic test_len0();
      run_job(0, 0, 0, 1'b0, 1'b0);
      checks++; if (done_q.size() != 1) begin errors++; $display("FAIL len0 ndone got=%0d exp=1", done_q.size()); end
      checks++; if ((done_q.size() > 0 ? done_q[0] : -1) != t0 + 1) begin errors++; $display("FAIL len0 done_cyc got=%0d exp=%0d", (done_q.size() > 0 ? done_q[0] : -1), t0 + 1); end
      checks++; if (req_cnt != 0) begin errors++; $display("FAIL len0 req_cycles got=%0d exp=0", req_cnt); end
      checks++; if (err_q.size() != 0) begin errors++; $display("FAIL len0 nerr got=%0d exp=0", err_q.size()); end
   endtask

   task automatic test_wait_timeout();
      run_job(4, 0, 0, 1'b0, 1'b0);
      checks++; if (beat_q.size() != 0) begin errors++; $display("FAIL wait_to nbeats got=%0d exp=0", beat_q.size()); end
      checks++; if (err_q.size() != 1 || err_q[0] != t0 + 1 + T) begin errors++; $display("FAIL wait_to err n=%0d first=%0d exp_cyc=%0d", err_q.size(), (err_q.size() > 0 ? err_q[0] : -1), t0 + 1 + T); end
      checks++; if (done_q.size() != 1 || done_q[0] != t0 + 2 + T) begin errors++; $display("FAIL wait_to done n=%0d first=%0d exp_cyc=%0d", done_q.size(), (done_q.size() > 0 ? done_q[0] : -1), t0 + 2 + T); end
      checks++; if (req_cnt != T) begin errors++; $display("FAIL wait_to req_cycles got=%0d exp=%0d", req_cnt, T); end
   endtask

   task automatic test_lost_grant();
      int d;
      d = $urandom_range(0, 4);
      run_job(5, d, 3, 1'b0, 1'b0);
      checks++; if (beat_q.size() != 2) begin errors++; $display("FAIL lost nbeats got=%0d exp=2", beat_q.size()); end
      checks++; if (err_q.size() != 1 || err_q[0] != t0 + 5 + d) begin errors++; $display("FAIL lost err n=%0d first=%0d exp_cyc=%0d", err_q.size(), (err_q.size() > 0 ? err_q[0] : -1), t0 + 5 + d); end
      checks++; if (done_q.size() != 1 || done_q[0] != t0 + 6 + d) begin errors++; $display("FAIL lost done n=%0d first=%0d exp_cyc=%0d", done_q.size(), (done_q.size() > 0 ? done_q[0] : -1), t0 + 6 + d); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL lost busy_after got=%b exp=0", bus.busy); end
   endtask

   task automatic test_rel_timeout();
      run_job(2, 1, 1 + 2 + T + 1, 1'b0, 1'b0);
      checks++; if (beat_q.size() != 2) begin errors++; $display("FAIL rel_to nbeats got=%0d exp=2", beat_q.size()); end
      checks++; if (done_q.size() != 1 || done_q[0] != e_done) begin errors++; $display("FAIL rel_to done n=%0d first=%0d exp_cyc=%0d", done_q.size(), (done_q.size() > 0 ? done_q[0] : -1), e_done); end
      checks++; if (err_q.size() != 1 || err_q[0] != e_done) begin errors++; $display("FAIL rel_to err n=%0d first=%0d exp_cyc=%0d", err_q.size(), (err_q.size() > 0 ? err_q[0] : -1), e_done); end
   endtask

   task automatic test_busy_start();
      int L;
      L = $urandom_range(1, 15);
      run_job(L, $urandom_range(0, 3), 1 + L, 1'b1, 1'b0);
      checks++; if (beat_q.size() != L) begin errors++; $display("FAIL busy_start nbeats got=%0d exp=%0d", beat_q.size(), L); end
      checks++; if (done_q.size() != 1 || done_q[0] != e_done) begin errors++; $display("FAIL busy_start done n=%0d first=%0d exp_cyc=%0d", done_q.size(), (done_q.size() > 0 ? done_q[0] : -1), e_done); end
      checks++; if (req_cnt != e_r - t0 - 1) begin errors++; $display("FAIL busy_start req_cycles got=%0d exp=%0d", req_cnt, e_r - t0 - 1); end
   endtask

   task automatic test_reset_mid_xfer();
      @(posedge clock); #1;
      bus.start = 1'b1; bus.len = 4'd4; t0 = cyc;
      @(posedge clock); #1;
      bus.start = 1'b0; bus.gnt = 1'b1;
      repeat (2) begin @(posedge clock); #1; end
      #3 reset_n = 1'b0;
      #1;
      checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL midrst req got=%b exp=0", bus.req); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst busy got=%b exp=0", bus.busy); end
      checks++; if (bus.beat !== 1'b0) begin errors++; $display("FAIL midrst beat got=%b exp=0", bus.beat); end
      checks++; if (bus.beat_idx !== 4'd0) begin errors++; $display("FAIL midrst beat_idx got=%0d exp=0", bus.beat_idx); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL midrst done got=%b exp=0", bus.done); end
      checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL midrst err got=%b exp=0", bus.err); end
      bus.gnt = 1'b0;
      done_q = {}; err_q = {};
      mon_en = 1'b1;
      repeat (2) @(posedge clock);
      #3;
      checks++; if (done_q.size() + err_q.size() != 0) begin errors++; $display("FAIL midrst pulses got=%0d exp=0", done_q.size() + err_q.size()); end
      reset_n = 1'b1;
      bus.start = 1'b1; bus.len = 4'd1; t0 = cyc;
      run_job(1, 0, 2, 1'b0, 1'b1);
      checks++; if (beat_q.size() != 1) begin errors++; $display("FAIL midrst_job nbeats got=%0d exp=1", beat_q.size()); end
      checks++; if (req_first != t0 + 1) begin errors++; $display("FAIL midrst_job req_rise got=%0d exp=%0d", req_first, t0 + 1); end
      checks++; if (done_q.size() != 1 || done_q[0] != t0 + 4) begin errors++; $display("FAIL midrst_job done n=%0d first=%0d exp_cyc=%0d", done_q.size(), (done_q.size() > 0 ? done_q[0] : -1), t0 + 4); end
      checks++; if (err_q.size() != 0) begin errors++; $display("FAIL midrst_job nerr got=%0d exp=0", err_q.size()); end
   endtask

   task automatic test_random();
      int L, d, W, k;
      for (int n = 0; n < 12; n++) begin
         L = $urandom_range(0, 15);
         d = $urandom_range(0, T + 1);
         k = $urandom_range(0, 3);
         case (k)
            0: W = 0;
            1: W = 1 + L + $urandom_range(0, 3);
            2: W = (L > 0) ? $urandom_range(1, L) : 0;
            default: W = 1 + L + T + $urandom_range(0, 2);
         endcase
         run_job(L, d, W, n[0], 1'b0);
         checks++; if (beat_q.size() != e_nb) begin errors++; $display("FAIL rand%0d nbeats got=%0d exp=%0d (L=%0d d=%0d W=%0d)", n, beat_q.size(), e_nb, L, d, W); end
         for (int i = 0; i < beat_q.size() && i < e_nb; i++) begin
            checks++; if (beat_q[i] != i || beat_cyc_q[i] != e_x + i) begin errors++; $display("FAIL rand%0d beat[%0d] idx=%0d cyc=%0d exp_idx=%0d exp_cyc=%0d", n, i, beat_q[i], beat_cyc_q[i], i, e_x + i); end
         end
         checks++; if (done_q.size() != 1 || done_q[0] != e_done) begin errors++; $display("FAIL rand%0d done n=%0d first=%0d exp_cyc=%0d", n, done_q.size(), (done_q.size() > 0 ? done_q[0] : -1), e_done); end
         checks++; if (err_q.size() != e_errq.size()) begin errors++; $display("FAIL rand%0d nerr got=%0d exp=%0d", n, err_q.size(), e_errq.size()); end
         for (int i = 0; i < err_q.size() && i < e_errq.size(); i++) begin
            checks++; if (err_q[i] != e_errq[i]) begin errors++; $display("FAIL rand%0d err_cyc[%0d] got=%0d exp=%0d", n, i, err_q[i], e_errq[i]); end
         end
         checks++; if (req_cnt != e_r - t0 - 1) begin errors++; $display("FAIL rand%0d req_cycles got=%0d exp=%0d", n, req_cnt, e_r - t0 - 1); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_len0();
      test_wait_timeout();
      test_lost_grant();
      test_rel_timeout();
      test_busy_start();
      test_reset_mid_xfer();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/arb_requester.md
ARB_REQUESTER -- requirements
Module: arb_requester

Interface
REQ-001 Parameter LEN_W, default 4, SHALL set the width of the burst-length input and the beat index.
REQ-002 Parameter TIMEOUT_CYC, default 16, SHALL set the maximum number of cycles spent in WAIT or REL before a timeout error.
REQ-003 clock  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 start  input  1  SHALL be a one-cycle job request from the local client.
REQ-006 len  input  LEN_W  SHALL give the number of beats for the job; it is sampled only when start is accepted.
REQ-007 gnt  input  1  SHALL be the active-high grant from the arbiter for this agent.
REQ-008 req  output  1  SHALL be the active-high request to the arbiter.
REQ-009 busy  output  1  SHALL be high whenever the FSM is not in IDLE.
REQ-010 beat  output  1  SHALL be high for exactly one cycle per transferred beat.
REQ-011 beat_idx  output  LEN_W  SHALL give the 0-based index of the current beat.
REQ-012 done  output  1  SHALL be a one-cycle pulse marking job end.
REQ-013 err  output  1  SHALL be a one-cycle pulse marking a timeout or lost grant.

Function
REQ-014 The FSM SHALL have four states: IDLE, WAIT, XFER and REL, held in a registered state with a combinational next-state.
REQ-015 In IDLE, start=1 with len!=0 SHALL latch len, clear the cycle counter and move to WAIT.
REQ-016 In IDLE, start=1 with len==0 SHALL pulse done on the next cycle, leave req at 0 and stay in IDLE.
REQ-017 start SHALL be ignored in every state other than IDLE.
REQ-018 req SHALL equal 1 exactly in WAIT and XFER, and SHALL be decoded from registered state, so it rises in the cycle after start is accepted.
REQ-019 In WAIT, gnt=1 SHALL move the FSM to XFER with beat_idx=0; otherwise the cycle counter SHALL increment.
REQ-020 In WAIT, when the counter reaches TIMEOUT_CYC-1 with gnt=0, the FSM SHALL move to REL and pulse err.
REQ-021 In XFER, beat SHALL equal gnt.
REQ-022 In XFER, each cycle with gnt=1 SHALL advance beat_idx by 1.
REQ-023 In XFER, the beat with beat_idx == latched len-1 SHALL be the last, and the FSM SHALL move to REL after it.
REQ-024 In XFER, gnt=0 SHALL move the FSM to REL, produce no beat in that cycle, and pulse err (grant lost).
REQ-025 In REL, req SHALL be 0, and the FSM SHALL wait for gnt=0.
REQ-026 In REL, on gnt=0 the FSM SHALL return to IDLE and pulse done, including after an error.
REQ-027 In REL, TIMEOUT_CYC cycles with gnt stuck at 1 SHALL pulse err, force the FSM to IDLE and pulse done.
REQ-028 done and err SHALL be registered pulses, never high for two consecutive cycles from a single event, and may coincide only per REQ-027.
REQ-029 An illegal state encoding SHALL return the FSM to IDLE on the next edge.
REQ-030 The cycle counter SHALL saturate and never wrap.
REQ-031 beat_idx SHALL hold its value outside XFER.

Reset
REQ-032 reset_n=0 SHALL immediately force state=IDLE and clear req, busy, beat, beat_idx, done, err and the counters to 0, regardless of clock.
REQ-033 Reset asserted mid-job SHALL abandon the job with no done or err pulse; after release the block SHALL accept start on the first rising edge.

Verification
REQ-034 The bench SHALL cover: len=3, gnt rising 2 cycles after req -> exactly 3 beats with beat_idx 0,1,2; req falls after beat 2; done pulses once when gnt falls.
REQ-035 The bench SHALL cover: len=0 with start -> done one cycle later; req stays 0; err stays 0.
REQ-036 The bench SHALL cover: len=4, gnt held 0 -> err pulse after 16 cycles in WAIT, then done after REL; zero beats.
REQ-037 The bench SHALL cover: len=5, gnt dropped after beat_idx 1 -> err pulse, exactly 2 beats counted, FSM returns to IDLE once gnt=0.
REQ-038 The bench SHALL cover: start pulsed again while busy -> ignored; a single job completes.
REQ-039 The bench SHALL cover: reset_n pulsed low during XFER between clock edges -> all outputs 0 immediately; no done or err; a new job with len=1 then completes normally.
